// File: rtl/ddr5_dfi_phy_responder.sv
// PHY-side DFI responder: init delay, write sink into a backing store, fixed-latency
// read return through a credit-limited response FIFO, sticky protocol error flags.

`ifndef DDR_CMD_RD
`define DDR_CMD_RD 32'h0000_0001
`endif
`ifndef DDR_CMD_WR
`define DDR_CMD_WR 32'h0000_0002
`endif

module ddr5_dfi_phy_responder #(
    parameter int DFI_ADDR_WIDTH = 24,
    parameter int DFI_BANK_WIDTH = 4,
    parameter int DFI_CMD_WIDTH  = 32,
    parameter int DFI_DATA_BYTES = 16,
    parameter int MEM_DEPTH      = 256,
    parameter int RD_LAT         = 4,
    parameter int RSP_FIFO_DEPTH = 8,
    parameter int INIT_CYCLES    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DFI_ADDR_WIDTH-1:0]   dfi_ca_addr,
    input  logic [DFI_BANK_WIDTH-1:0]   dfi_ca_bank,
    input  logic [DFI_CMD_WIDTH-1:0]    dfi_cmd,
    input  logic                        dfi_cmd_valid,
    output logic                        dfi_cmd_ready,
    input  logic [8*DFI_DATA_BYTES-1:0] dfi_wr_data,
    input  logic                        dfi_wr_valid,
    output logic                        dfi_wr_ready,
    output logic [8*DFI_DATA_BYTES-1:0] dfi_rd_data,
    output logic                        dfi_rd_valid,
    input  logic                        dfi_rd_ready,
    output logic                        dfi_phy_up,
    output logic                        err_wr_nodata,
    output logic                        err_unknown_cmd,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 wr_count
);

    localparam int DATA_W  = 8 * DFI_DATA_BYTES;
    localparam int MEM_AW  = $clog2(MEM_DEPTH);
    localparam int FIFO_AW = $clog2(RSP_FIFO_DEPTH);
    localparam int CRED_W  = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int INIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_UP   = 1'b1;

    logic [0:0]        state;
    logic [INIT_W-1:0] init_cnt;
    logic [CRED_W-1:0] credits;

    logic [DATA_W-1:0] store [MEM_DEPTH];

    logic [RD_LAT-1:0] pipe_valid;
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    logic [DATA_W-1:0] fifo_mem [RSP_FIFO_DEPTH];
    logic [FIFO_AW:0]  fifo_wr_ptr;
    logic [FIFO_AW:0]  fifo_rd_ptr;
    logic              fifo_empty;

    logic [DFI_BANK_WIDTH+DFI_ADDR_WIDTH-1:0] full_idx;
    logic [MEM_AW-1:0] cmd_idx;
    logic              unused_idx_bits;

    logic accept;
    logic is_rd;
    logic is_wr;
    logic acc_rd;
    logic acc_wr_data;
    logic acc_wr_nodata;
    logic acc_unknown;
    logic push;
    logic pop;

    assign full_idx        = {dfi_ca_bank, dfi_ca_addr};
    assign cmd_idx         = full_idx[MEM_AW-1:0];
    assign unused_idx_bits = ^full_idx;

    assign dfi_phy_up    = (state == S_UP);
    assign dfi_cmd_ready = dfi_phy_up && (credits < CRED_W'(RSP_FIFO_DEPTH));
    assign dfi_wr_ready  = dfi_phy_up;

    assign is_rd         = (dfi_cmd == DFI_CMD_WIDTH'(`DDR_CMD_RD));
    assign is_wr         = (dfi_cmd == DFI_CMD_WIDTH'(`DDR_CMD_WR));
    assign accept        = dfi_cmd_valid && dfi_cmd_ready;
    assign acc_rd        = accept && is_rd;
    assign acc_wr_data   = accept && is_wr && dfi_wr_valid;
    assign acc_wr_nodata = accept && is_wr && !dfi_wr_valid;
    assign acc_unknown   = accept && !is_rd && !is_wr;

    assign fifo_empty   = (fifo_wr_ptr == fifo_rd_ptr);
    assign push         = pipe_valid[RD_LAT-1];
    assign pop          = dfi_rd_valid && dfi_rd_ready;
    assign dfi_rd_valid = !fifo_empty;
    assign dfi_rd_data  = fifo_empty ? '0 : fifo_mem[fifo_rd_ptr[FIFO_AW-1:0]];

    // Init sequencer: S_UP is terminal until the next reset.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation order cannot change the result.
        if (rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                state <= S_UP;
            end
        end
    end

    // NOTE: the backing store, data pipeline and FIFO storage carry no reset; only
    // the valid bits and pointers qualify them, so clearing storage would buy nothing.
    always_ff @(posedge clk) begin
        if (acc_wr_data) begin
            store[cmd_idx] <= dfi_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_rd) begin
            pipe_data[0] <= store[cmd_idx];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= acc_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr[FIFO_AW-1:0]] <= pipe_data[RD_LAT-1];
        end
    end

    // Credits cover pipeline plus FIFO occupancy, so a push never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            credits     <= '0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            end
            if (acc_rd && !pop) begin
                credits <= credits + 1'b1;
            end else if (!acc_rd && pop) begin
                credits <= credits - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count        <= '0;
            wr_count        <= '0;
            err_wr_nodata   <= 1'b0;
            err_unknown_cmd <= 1'b0;
        end else begin
            if (acc_rd) begin
                rd_count <= rd_count + 16'd1;
            end
            if (acc_wr_data) begin
                wr_count <= wr_count + 16'd1;
            end
            if (acc_wr_nodata) begin
                err_wr_nodata <= 1'b1;
            end
            if (acc_unknown) begin
                err_unknown_cmd <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ddr5_dfi_phy_responder.md
Name: ddr5_dfi_phy_responder

Overview:
- PHY-side end of the controller DFI command/data interface.
- Synthesizable responder for subsystem simulation and FPGA bring-up in place of a real PHY.
- Runs the init delay, sinks write commands and data into a small backing store, and returns read data after a fixed latency through a credit-limited response FIFO.
- Reports sticky protocol errors.

Parameters:
DFI_ADDR_WIDTH, 24, width of dfi_ca_addr
DFI_BANK_WIDTH, 4, width of dfi_ca_bank
DFI_CMD_WIDTH, 32, width of dfi_cmd
DFI_DATA_BYTES, 16, data bus bytes (data width = 8*DFI_DATA_BYTES)
MEM_DEPTH, 256, backing-store entries (power of 2, >=2)
RD_LAT, 4, command-accept to rd_valid latency in cycles (>=1)
RSP_FIFO_DEPTH, 8, max outstanding reads (power of 2, >=2)
INIT_CYCLES, 16, cycles after reset before phy_up (>=1)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
dfi_ca_addr  in  DFI_ADDR_WIDTH  command address
dfi_ca_bank  in  DFI_BANK_WIDTH  command bank
dfi_cmd  in  DFI_CMD_WIDTH  command code, compared against `DDR_CMD_RD / `DDR_CMD_WR (ddr_defines.svh)
dfi_cmd_valid  in  1  command valid
dfi_cmd_ready  out  1  command accepted when valid & ready
dfi_wr_data  in  8*DFI_DATA_BYTES  write data
dfi_wr_valid  in  1  write data valid, must coincide with WR command
dfi_wr_ready  out  1  write data accepted
dfi_rd_data  out  8*DFI_DATA_BYTES  read data, FIFO head
dfi_rd_valid  out  1  read data valid
dfi_rd_ready  in  1  read data consumed when valid & ready
dfi_phy_up  out  1  init complete
err_wr_nodata  out  1  sticky: WR accepted without wr_valid
err_unknown_cmd  out  1  sticky: accepted command neither RD nor WR
rd_count  out  16  wrapping count of accepted reads
wr_count  out  16  wrapping count of accepted writes

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset values: phy_up=0, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, both err flags=0, both counters=0. Init counter, latency pipeline, FIFO and credits are cleared.
- Backing store is not reset. Reading an unwritten location returns undefined data.
- Reset asserted mid-operation discards all in-flight reads. The first cycle after rst deasserts is INIT cycle 0.
- FSM states:
  - S_INIT: init counter increments each cycle. When it reaches INIT_CYCLES-1, go to S_UP next cycle. phy_up is therefore high in the INIT_CYCLES-th cycle after reset release.
  - S_UP: terminal until reset. phy_up=1.
- cmd_ready = phy_up & (credits < RSP_FIFO_DEPTH). wr_ready = phy_up.
- credits = reads accepted and not yet popped (in pipeline plus in FIFO):
  - +1 on read accept, -1 on rd_valid & rd_ready.
  - Both events in the same cycle leave credits unchanged.
  - The FIFO therefore never overflows.
- Store index = {ca_bank, ca_addr} truncated to log2(MEM_DEPTH) LSBs.
- Accept = cmd_valid & cmd_ready. At most one command per cycle.
- On accept, WR with wr_valid: store[index] <= wr_data; wr_count++.
- On accept, WR without wr_valid: no store update, err_wr_nodata set; wr_count unchanged.
- On accept, RD: store[index] is sampled into stage 0 of an RD_LAT-deep valid+data shift pipeline; rd_count++.
  - A write in cycle N is visible to a read accepted in cycle N+1 or later.
- On accept, other codes: dropped, err_unknown_cmd set.
- wr_valid without an accepted WR command is ignored.
- Pipeline output pushes into the FIFO. Read accepted at edge N gives rd_valid=1 from edge N+RD_LAT when the FIFO was empty. Reads return in accept order.
- rd_valid = FIFO not empty. rd_data = FIFO head, 0 when empty. rd_data is held stable while rd_valid & !rd_ready.
- Push and pop in the same cycle are both performed. Push into an empty FIFO does not bypass; data appears the next cycle.
- Counters wrap 16'hFFFF -> 0. Sticky errors clear only on rst.
- Commands presented before phy_up are not accepted (cmd_ready=0) and cause no error.

Test Plan:
1. Release rst, cmd_valid=1 held -> cmd_ready and phy_up rise together exactly 16 cycles after release; no command accepted earlier.
2. WR bank 2, addr 0x000005, data 0xA5..A5 with wr_valid, then RD same address the next cycle -> rd_valid exactly 4 cycles after RD accept with data 0xA5..A5; wr_count=1, rd_count=1.
3. rd_ready=0, issue 10 back-to-back RDs -> exactly 8 accepted, cmd_ready=0 afterwards. Raise rd_ready -> 8 beats return in address order, cmd_ready reasserts the cycle after the first pop.
4. Credits at 8, pop and a new RD offered in the same cycle -> RD not accepted that cycle. Credits at 7 with pop and RD in the same cycle -> RD accepted, credits stay 7.
5. WR with wr_valid=0, then cmd=0x7F -> err_wr_nodata=1 then err_unknown_cmd=1, store location unchanged (verified by a later RD), counters unchanged.
6. rst pulsed 1 cycle with 3 reads in flight -> rd_valid=0 the next cycle, all outputs at reset values, no stale beats after the re-init 16 cycles.
